ar_fifo_reader: RTL and testbench
=================================

AR_FIFO_READER -- requirements
Module: ar_fifo_reader

Interface
REQ-001 Parameter: width, 128, data word width in bits.
REQ-002 Parameter: burst_len, 16, beats per M_LAST frame; legal range 2..65536.
REQ-003 Signal: CLK  input  1  clock, all logic rising-edge.
REQ-004 Signal: RST_N  input  1  reset, synchronous, active-low.
REQ-005 Signal: CLR  input  1  synchronous clear, active-high.
REQ-006 Signal: EN  input  1  pull enable; 0 inhibits new FIFO pops.
REQ-007 Signal: F_EMPTY_N  input  1  upstream FIFO has data.
REQ-008 Signal: F_DATA  input  width  upstream FIFO head word, valid while F_EMPTY_N=1.
REQ-009 Signal: F_DEQ  output  1  pop upstream FIFO this cycle.
REQ-010 Signal: M_VALID  output  1  M_DATA holds a valid beat.
REQ-011 Signal: M_READY  input  1  downstream accepts beat.
REQ-012 Signal: M_DATA  output  width  beat data, registered.
REQ-013 Signal: M_LAST  output  1  final beat of a burst_len frame.
REQ-014 Signal: COUNT  output  32  total beats delivered, wrapping.

Function
REQ-015 Block SHALL hold a 2-entry in-order output buffer with occupancy states EMPTY(0), ONE(1), TWO(2).
REQ-016 F_DEQ SHALL equal EN && F_EMPTY_N && (state != TWO); no combinational path from M_READY to F_DEQ.
REQ-017 Popped word SHALL be captured on the F_DEQ edge and presented on M_DATA no earlier than the next cycle (pop-to-valid latency 1 cycle when buffer was EMPTY).
REQ-018 M_VALID SHALL equal (state != EMPTY); M_DATA SHALL be the oldest buffered word; all outputs registered or decoded from registers only.
REQ-019 Transfer SHALL occur when M_VALID && M_READY; M_DATA/M_LAST SHALL stay stable while M_VALID && !M_READY.
REQ-020 Transitions: pop only -> occupancy+1; transfer only -> occupancy-1; both or neither -> unchanged; pop and transfer in ONE SHALL replace the head with the popped word.
REQ-021 With F_EMPTY_N=1, EN=1, M_READY=1 continuously, block SHALL sustain one beat per cycle in state ONE.
REQ-022 EN deasserted SHALL stop pops the same cycle; buffered words SHALL still drain to downstream.
REQ-023 F_EMPTY_N dropping SHALL drop F_DEQ the same cycle; F_DATA SHALL NOT be sampled when F_DEQ=0.
REQ-024 COUNT SHALL increment by 1 per transfer, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-025 Beat ordering SHALL match upstream FIFO pop order exactly; no word duplicated or dropped.

Reset
REQ-026 RST_N=0 or CLR=1 at a clock edge SHALL force state EMPTY, M_VALID=0, F_DEQ=0, M_LAST=0, COUNT=0, beat counter=0.
REQ-027 Reset/clear mid-operation SHALL discard buffered words; F_DEQ SHALL be 0 during the reset/clear cycle so no upstream word is lost in that cycle.
REQ-028 M_DATA SHALL NOT be reset; value is don't-care while M_VALID=0.

Configuration
REQ-029 Macro AR_FIFO_READER_LAST_EN defined: a beat counter (modulo burst_len) SHALL advance per transfer and M_LAST SHALL be 1 while counter == burst_len-1 and M_VALID=1.
REQ-030 Macro AR_FIFO_READER_LAST_EN undefined: beat counter SHALL be absent and M_LAST SHALL be constant 0; all other behaviour identical.

Verification
REQ-031 Reset: RST_N=0 one cycle, F_EMPTY_N=1 -> F_DEQ=0, M_VALID=0, COUNT=0; after release, F_DEQ=1 next cycle.
REQ-032 Streaming: upstream words 0x1..0x40, EN=1, M_READY=1 -> 64 beats in order, one per cycle after first, COUNT=64.
REQ-033 Backpressure: M_READY=0 with 5 words available -> exactly 2 pops, F_DEQ=0, M_DATA=0x1 stable; M_READY=1 -> remaining 3 popped, order 0x1..0x5 intact.
REQ-034 LAST (macro defined, burst_len=4): 12 beats streamed -> M_LAST=1 on beats 4, 8, 12 only; macro undefined -> M_LAST=0 throughout.
REQ-035 Mid-stream CLR with state TWO -> next cycle M_VALID=0, COUNT=0, no F_DEQ in CLR cycle; subsequent words delivered starting at upstream head.
REQ-036 COUNT wrap: preload via 2^32-1 transfers (or forced) then 1 transfer -> COUNT=0x00000000.

Source files
------------

// File: rtl/ar_fifo_reader.sv
// Pulls words from an upstream FIFO into a 2-entry registered output buffer.
// Define AR_FIFO_READER_LAST_EN to enable the M_LAST beat counter.
module ar_fifo_reader #(
    parameter int width     = 128,
    parameter int burst_len = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             EN,
    input  logic             F_EMPTY_N,
    input  logic [width-1:0] F_DATA,
    output logic             F_DEQ,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [width-1:0] M_DATA,
    output logic             M_LAST,
    output logic [31:0]      COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [width-1:0] head_q, tail_q;
    logic [31:0]      count_q;
    logic             clr, pop, xfer;
    logic             head_ld, head_shift, tail_ld;

    // Clear also gates the pop so no upstream word is consumed in that cycle
    assign clr  = !RST_N || CLR;
    assign pop  = EN && F_EMPTY_N && (state_q != TWO) && !clr;
    assign xfer = (state_q != EMPTY) && M_READY;

    assign F_DEQ   = pop;
    assign M_VALID = (state_q != EMPTY);
    assign M_DATA  = head_q;
    assign COUNT   = count_q;

    always_ff @(posedge CLK) begin
        if (clr) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        head_ld    = 1'b0;
        head_shift = 1'b0;
        tail_ld    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (pop) begin
                    state_d = ONE;
                    head_ld = 1'b1;
                end
            end
            ONE: begin
                if (pop && xfer) begin
                    head_ld = 1'b1;
                end else if (pop) begin
                    state_d = TWO;
                    tail_ld = 1'b1;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_d    = ONE;
                    head_shift = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Data storage carries no reset; contents are ignored while M_VALID=0
    always_ff @(posedge CLK) begin
        if (head_ld)         head_q <= F_DATA;
        else if (head_shift) head_q <= tail_q;
        if (tail_ld)         tail_q <= F_DATA;
    end

    always_ff @(posedge CLK) begin
        if (clr)       count_q <= 32'd0;
        else if (xfer) count_q <= count_q + 32'd1;
    end

`ifdef AR_FIFO_READER_LAST_EN
    localparam int BW = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(burst_len - 1);

    logic [BW-1:0] beat_q;

    always_ff @(posedge CLK) begin
        if (clr)
            beat_q <= '0;
        else if (xfer)
            beat_q <= (beat_q == LAST_IDX) ? '0 : beat_q + 1'b1;
    end

    assign M_LAST = M_VALID && (beat_q == LAST_IDX);
`else
    assign M_LAST = 1'b0;
`endif

endmodule

// File: tb/tb_ar_fifo_reader.sv
// Scoreboard bench for ar_fifo_reader: upstream FIFO model, ordering,
// backpressure, enable, clear, M_LAST framing and COUNT wrap.
module tb_ar_fifo_reader;

    localparam int W  = 32;
    localparam int BL = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         CLR = 1'b0;
    logic         EN = 1'b1;
    logic         F_EMPTY_N = 1'b0;
    logic [W-1:0] F_DATA = 32'hDEAD_BEEF;
    logic         F_DEQ;
    logic         M_VALID;
    logic         M_READY = 1'b1;
    logic [W-1:0] M_DATA;
    logic         M_LAST;
    logic [31:0]  COUNT;

    ar_fifo_reader #(.width(W), .burst_len(BL)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .EN(EN),
        .F_EMPTY_N(F_EMPTY_N), .F_DATA(F_DATA), .F_DEQ(F_DEQ),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .M_LAST(M_LAST), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    logic [W-1:0] src[$];
    logic [W-1:0] exp_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic [31:0]  n_xfer = 0;
    int           nbeat = 0;
    int           npops = 0;
    int           cyc = 0;
    int           first_x = -1;
    int           last_x = -1;
    bit           pop_pending = 0;
    bit           stall = 0;
    logic [W-1:0] stall_data = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_last(input int n);
`ifdef AR_FIFO_READER_LAST_EN
        return (n % BL) == (BL - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        F_EMPTY_N = (src.size() > 0);
        F_DATA    = (src.size() > 0) ? src[0] : 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (pop_pending) begin
            src.delete(0);
            pop_pending = 0;
        end
        drive();
    endtask

    task automatic push(input logic [W-1:0] w);
        src.push_back(w);
        drive();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        npops = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((src.size() > 0 || exp_q.size() > 0 || M_VALID) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Scoreboard: pops push expected words, transfers pop and compare
    always @(negedge CLK) begin
        cyc++;
        if (!RST_N || CLR) begin
            exp_q.delete();
            n_xfer = 0;
            nbeat = 0;
            stall = 0;
            pop_pending = 0;
        end else begin
            chk("count", COUNT, n_xfer);
            if (stall && M_VALID) chk("stable", M_DATA, stall_data);
            if (M_VALID && M_READY) begin
                if (exp_q.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
                else chk("data", M_DATA, exp_q.pop_front());
                chk("last", {31'd0, M_LAST}, {31'd0, exp_last(nbeat)});
                nbeat++;
                n_xfer = n_xfer + 32'd1;
                last_x = cyc;
                if (first_x < 0) first_x = cyc;
            end
            if (F_DEQ) begin
                if (src.size() > 0) begin
                    exp_q.push_back(src[0]);
                    pop_pending = 1;
                    npops++;
                end else begin
                    chk("deq_when_empty", 32'd1, 32'd0);
                end
            end
            stall = M_VALID && !M_READY;
            stall_data = M_DATA;
        end
    end

    initial begin
        // Reset with data waiting upstream
        for (int i = 1; i <= 64; i++) push(W'(i));
        RST_N = 1'b0;
        tick();
        @(negedge CLK); #1;
        chk("rst_deq", {31'd0, F_DEQ}, 32'd0);
        chk("rst_valid", {31'd0, M_VALID}, 32'd0);
        chk("rst_count", COUNT, 32'd0);
        chk("rst_last", {31'd0, M_LAST}, 32'd0);
        tick();
        RST_N = 1'b1;
        @(negedge CLK); #1;
        chk("rel_deq", {31'd0, F_DEQ}, 32'd1);

        // Streaming 64 words
        first_x = -1;
        drain("stream");
        chk("stream_count", COUNT, 32'd64);
        chk("stream_rate", 32'(last_x - first_x), 32'd63);

        // Backpressure
        do_reset();
        M_READY = 1'b0;
        for (int i = 1; i <= 5; i++) push(W'(i));
        repeat (8) tick();
        @(negedge CLK); #1;
        chk("bp_pops", 32'(npops), 32'd2);
        chk("bp_deq", {31'd0, F_DEQ}, 32'd0);
        chk("bp_data", M_DATA, 32'h1);
        chk("bp_valid", {31'd0, M_VALID}, 32'd1);
        tick();
        M_READY = 1'b1;
        drain("bp");
        chk("bp_pops_all", 32'(npops), 32'd5);
        chk("bp_count", COUNT, 32'd5);

        // Enable drop mid-stream
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h100 + W'(i));
        repeat (3) tick();
        EN = 1'b0;
        @(negedge CLK); #1;
        chk("en_deq", {31'd0, F_DEQ}, 32'd0);
        repeat (4) tick();
        chk("en_drained", {31'd0, M_VALID}, 32'd0);
        chk("en_pops", 32'(npops), 32'd3);
        EN = 1'b1;
        drain("en");

        // Clear while holding two words
        do_reset();
        M_READY = 1'b0;
        for (int i = 1; i <= 6; i++) push(32'hA0 + W'(i));
        repeat (4) tick();
        chk("pre_clr_pops", 32'(npops), 32'd2);
        CLR = 1'b1;
        @(negedge CLK); #1;
        chk("clr_deq", {31'd0, F_DEQ}, 32'd0);
        tick();
        CLR = 1'b0;
        @(negedge CLK); #1;
        chk("clr_valid", {31'd0, M_VALID}, 32'd0);
        chk("clr_count", COUNT, 32'd0);
        chk("clr_head", src[0], 32'hA3);
        tick();
        M_READY = 1'b1;
        drain("clr");
        chk("clr_count_after", COUNT, 32'd4);

        // COUNT wrap
        @(posedge CLK); #2;
        force dut.count_q = 32'hFFFF_FFFF;
        n_xfer = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        @(negedge CLK); #1;
        chk("wrap_pre", COUNT, 32'hFFFF_FFFF);
        tick();
        push(32'h55);
        drain("wrap");
        chk("wrap_count", COUNT, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
